// File: rtl/frodo_mac4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frodo_mac4 : four-lane 8x16 multiply-accumulate, mod 2^16 per lane       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module frodo_mac4 #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             sub,
    input  logic [63:0]      init_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       short_data_0,
    input  logic [7:0]       short_data_1,
    input  logic [7:0]       short_data_2,
    input  logic [7:0]       short_data_3,
    input  logic [15:0]      long_data_0,
    input  logic [15:0]      long_data_1,
    input  logic [15:0]      long_data_2,
    input  logic [15:0]      long_data_3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t           r_state;
    logic [15:0]      r_acc  [4];
    logic [15:0]      r_prod [4];
    logic             r_pvld;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_nterms;
    logic             r_sub;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic [7:0]       w_short [4];
    logic [15:0]      w_long  [4];
    logic [15:0]      w_prod  [4];
    logic             w_beat;
    logic             w_load;
    logic             w_last;

    assign w_short[0] = short_data_0;
    assign w_short[1] = short_data_1;
    assign w_short[2] = short_data_2;
    assign w_short[3] = short_data_3;
    assign w_long[0]  = long_data_0;
    assign w_long[1]  = long_data_1;
    assign w_long[2]  = long_data_2;
    assign w_long[3]  = long_data_3;

    // A 16-bit product of the sign-extended operand is exact mod 2^16.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic [15:0] w_ext;
            assign w_ext     = {{8{w_short[i][7]}}, w_short[i]};
            assign w_prod[i] = w_ext * w_long[i];
        end
    endgenerate

    // in_ready is only ever high in ACC, so w_beat needs no state decode.
    assign w_beat = in_valid & r_in_ready;
    assign w_load = start & ((r_state == S_IDLE) | ((r_state == S_OUT) & out_ready));
    assign w_last = (r_cnt == (r_nterms - {{(CNT_W-1){1'b0}}, 1'b1}));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_pvld      <= 1'b0;
            r_cnt       <= '0;
            r_nterms    <= '0;
            r_sub       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]  <= '0;
                r_prod[i] <= '0;
            end
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_pvld      <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_pvld <= w_beat;
            for (int i = 0; i < 4; i++) begin
                if (w_beat) begin
                    r_prod[i] <= w_prod[i];
                end
                if (w_load) begin
                    r_acc[i] <= init_data[16*i +: 16];
                end else if (r_pvld) begin
                    r_acc[i] <= r_sub ? (r_acc[i] - r_prod[i]) : (r_acc[i] + r_prod[i]);
                end
            end

            case (r_state)
                S_ACC: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (w_last) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state     <= S_OUT;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    if (w_load) begin
                        r_nterms <= n_terms;
                        r_sub    <= sub;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (n_terms == '0) begin
                            r_state     <= S_OUT;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state     <= S_ACC;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end
                    end else if ((r_state == S_OUT) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_out_valid ? {r_acc[3], r_acc[2], r_acc[1], r_acc[0]} : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_frodo_mac4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frodo_mac4 : directed vector bench for frodo_mac4                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_frodo_mac4;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] n_terms = '0;
    logic             sub = 1'b0;
    logic [63:0]      init_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      ops_sh = '0;
    logic [63:0]      ops_lg = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_data;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frodo_mac4 #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .clear        (clear),
        .n_terms      (n_terms),
        .sub          (sub),
        .init_data    (init_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .short_data_0 (ops_sh[7:0]),
        .short_data_1 (ops_sh[15:8]),
        .short_data_2 (ops_sh[23:16]),
        .short_data_3 (ops_sh[31:24]),
        .long_data_0  (ops_lg[15:0]),
        .long_data_1  (ops_lg[31:16]),
        .long_data_2  (ops_lg[47:32]),
        .long_data_3  (ops_lg[63:48]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    typedef struct {
        logic [CNT_W-1:0] n;
        logic             sb;
        logic [63:0]      init;
        logic [31:0]      sh;
        logic [63:0]      lg;
        logic [7:0]       mask;
        logic             extra;
        logic [63:0]      exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic sb, input logic [63:0] init);
        n_terms   = n;
        sub       = sb;
        init_data = init;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        n_terms   = '1;
        sub       = ~sb;
        init_data = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Feeds beats following a repeating 8-bit valid mask until n are accepted.
    task automatic feed(input int n, input logic [7:0] mask, input logic extra);
        int acc = 0;
        int idx = 0;
        while (acc < n && idx < 200) begin
            in_valid = mask[idx % 8];
            if (in_valid && in_ready) acc++;
            idx++;
            @(negedge clk);
        end
        in_valid = extra;
        if (acc < n) chk("feed_timeout", 64'(acc), 64'(n));
    endtask

    task automatic wait_out(input int exp_lat, input string tag);
        int   c   = 0;
        logic irb = 1'b0;
        while (!out_valid && c < 20) begin
            irb |= in_ready;
            @(negedge clk);
            c++;
        end
        irb |= in_ready;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_latency"}, 64'(c), 64'(exp_lat));
        chk({tag, "_inready_low"}, 64'(irb), 64'd0);
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{11'd1, 1'b0, 64'h0, 32'h0202_0202, 64'h1234_1234_1234_1234, 8'hFF, 1'b0, 64'h2468_2468_2468_2468};
        vt[1] = '{11'd3, 1'b0, 64'h0005, 32'hFFFF_FFFF, 64'h0001_0001_0001_0001, 8'hFF, 1'b0, 64'hFFFD_FFFD_FFFD_0002};
        vt[2] = '{11'd3, 1'b1, 64'h0005, 32'hFFFF_FFFF, 64'h0001_0001_0001_0001, 8'hFF, 1'b0, 64'h0003_0003_0003_0008};
        vt[3] = '{11'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0101_0101, 64'h0001_0001_0001_0001, 8'hFF, 1'b0, 64'h0};
        vt[4] = '{11'd1, 1'b0, 64'h0, 32'h8080_8080, 64'h0002_0002_0002_0002, 8'hFF, 1'b0, 64'hFF00_FF00_FF00_FF00};
        vt[5] = '{11'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 32'h0202_0202, 64'h1234_1234_1234_1234, 8'hFF, 1'b0, 64'h0123_4567_89AB_CDEF};
        vt[6] = '{11'd2, 1'b0, 64'h0040_0030_0020_0010, 32'hFE00_817F, 64'h8000_FFFF_0003_0100, 8'hFF, 1'b0, 64'h0040_0030_FD26_FE10};
        vt[7] = '{11'd4, 1'b0, 64'h0, 32'h0202_0202, 64'h1234_1234_1234_1234, 8'hFF, 1'b0, 64'h91A0_91A0_91A0_91A0};
        vt[8] = '{11'd4, 1'b0, 64'h0, 32'h0202_0202, 64'h1234_1234_1234_1234, 8'h59, 1'b1, 64'h91A0_91A0_91A0_91A0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Table vectors, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            ops_sh = vt[v].sh;
            ops_lg = vt[v].lg;
            do_start(vt[v].n, vt[v].sb, vt[v].init);
            feed(int'(vt[v].n), vt[v].mask, vt[v].extra);
            wait_out((vt[v].n == 0) ? 0 : 1, tag);
            chk({tag, "_data"}, out_data, vt[v].exp);
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, "_single_cycle"}, 64'(out_valid), 64'd0);
        end

        // Back-pressure hold, then back-to-back reload
        out_ready = 1'b0;
        ops_sh = 32'h0202_0202;
        ops_lg = 64'h1234_1234_1234_1234;
        do_start(11'd1, 1'b0, 64'h0);
        feed(1, 8'hFF, 1'b0);
        wait_out(1, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("hold_data_%0d", i), out_data, 64'h2468_2468_2468_2468);
        end
        out_ready = 1'b1;
        ops_sh = 32'h0101_0101;
        ops_lg = 64'h0003_0003_0003_0003;
        do_start(11'd1, 1'b0, 64'h1);
        chk("b2b_inready", 64'(in_ready), 64'd1);
        chk("b2b_out_dropped", 64'(out_valid), 64'd0);
        feed(1, 8'hFF, 1'b0);
        wait_out(1, "b2b");
        chk("b2b_data", out_data, 64'h0003_0003_0003_0004);
        @(negedge clk);

        // Synchronous clear after 2 of 4 beats
        ops_sh = 32'h0202_0202;
        ops_lg = 64'h1234_1234_1234_1234;
        do_start(11'd4, 1'b0, 64'h0);
        feed(2, 8'hFF, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd0);
        chk("clr_out_data", out_data, 64'd0);
        begin
            logic seen = 1'b0;
            in_valid = 1'b1;
            for (int i = 0; i < 6; i++) begin
                seen |= out_valid;
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("clr_no_output", 64'(seen), 64'd0);
        end
        do_start(11'd1, 1'b0, 64'h0001_0002_0003_0004);
        feed(1, 8'hFF, 1'b0);
        wait_out(1, "after_clr");
        chk("after_clr_data", out_data, 64'h2469_246A_246B_246C);
        @(negedge clk);

        // Asynchronous reset during DRAIN
        do_start(11'd1, 1'b0, 64'h0);
        feed(1, 8'hFF, 1'b0);
        chk("drain_busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        chk("rstn_out_valid", 64'(out_valid), 64'd0);
        chk("rstn_out_data", out_data, 64'd0);
        chk("rstn_in_ready", 64'(in_ready), 64'd0);
        chk("rstn_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                seen |= out_valid;
            end
            chk("rstn_no_partial", 64'(seen), 64'd0);
        end
        do_start(11'd1, 1'b0, 64'h0);
        feed(1, 8'hFF, 1'b0);
        wait_out(1, "after_rstn");
        chk("after_rstn_data", out_data, 64'h2468_2468_2468_2468);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
